seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles per digit slot (1 kHz digit rate at 50 MHz); legal range 2..2^20.
REQ-002 SHALL have parameter BLINK_FRAMES, default 83, full scan frames per blink half-period (about 0.5 s); legal range 1..255.
REQ-003 SHALL have port clk  input  1  the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_digit  input  24  six 4-bit digit codes; bits [4k+3:4k] are digit k, digit 0 rightmost, digit 5 most significant.
REQ-006 SHALL have port i_dp  input  6  decimal point request per digit, active-high.
REQ-007 SHALL have port i_lzb  input  1  leading-zero blanking enable.
REQ-008 SHALL have port i_blink  input  6  blink mask per digit, active-high.
REQ-009 SHALL have port o_seg_enb  output  6  digit enables, one-hot active-low.
REQ-010 SHALL have port o_seg  output  7  segments, active-low, bit6=a ... bit0=g.
REQ-011 SHALL have port o_seg_dp  output  1  decimal point, active-low.
REQ-012 SHALL have port o_frame  output  1  one-cycle pulse when a new frame snapshot is loaded.

Function
REQ-013 Prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0; scan tick is asserted in the cycle where count == SCAN_DIV-1.
REQ-014 Digit index idx (0..5) SHALL advance on each scan tick; 5 wraps to 0.
REQ-015 On a scan tick with idx == 5, the block SHALL capture i_digit, i_dp, i_lzb and i_blink into a snapshot and pulse o_frame for exactly that cycle; the displayed data SHALL come only from the snapshot, so no frame mixes old and new digits.
REQ-016 Frame counter SHALL count snapshot loads 0..BLINK_FRAMES-1 and wrap; blink phase SHALL toggle at each wrap.
REQ-017 Outputs SHALL be registered: they reflect the idx and snapshot values present in the preceding cycle, giving 1 clk latency after an idx change.
REQ-018 o_seg_enb SHALL drive bit idx to 0 and all other bits to 1; exactly one bit is low at any time outside reset.
REQ-019 Decode SHALL be hex: 0=7'h01, 1=7'h4F, 2=7'h12, 3=7'h06, 4=7'h4C, 5=7'h24, 6=7'h20, 7=7'h0F, 8=7'h00, 9=7'h04, A=7'h08, b=7'h60, C=7'h31, d=7'h42, E=7'h30, F=7'h38.
REQ-020 When snapshot lzb = 1, digit k (k = 5..1) SHALL be blanked (o_seg = 7'h7F) if snapshot digits 5..k are all zero; digit 0 is never blanked; a blanked digit still shows its dp request.
REQ-021 When blink phase = 1 and the snapshot blink bit of the current digit = 1, the block SHALL force o_seg = 7'h7F and o_seg_dp = 1; o_seg_enb is unaffected.
REQ-022 o_seg_dp SHALL equal the inverse of the snapshot dp bit of the current digit, unless blink forces it off.
REQ-023 Input changes between snapshots SHALL have no effect on the outputs.

Reset
REQ-024 While rst = 1 at a clock edge: prescaler = 0, idx = 0, frame count = 0, blink phase = 0, snapshot = all zero (lzb = 0, blink = 0), o_seg_enb = 6'h3F, o_seg = 7'h7F, o_seg_dp = 1, o_frame = 0.
REQ-025 Reset asserted mid-frame SHALL abort the scan; the first clk after rst is released shows digit 0 using the zeroed snapshot (o_seg = 7'h01, o_seg_enb = 6'h3E).
REQ-026 No output SHALL be X after the first rst edge.

Verification (SCAN_DIV = 4, BLINK_FRAMES = 2)
REQ-027 Reset 1 clk, then release -> o_seg_enb sequence 3E, 3D, 3B, 37, 2F, 1F, 3E, with 4 clk per digit; o_frame pulses every 24 clk.
REQ-028 i_digit = 24'h123456, i_dp = 6'b000100, before the first frame load -> in the following frame, digit 0 shows o_seg = 7'h20 ('6'), digit 2 shows o_seg = 7'h4C ('4') with o_seg_dp = 0, digit 5 shows 7'h4F ('1').
REQ-029 i_digit = 24'h000705, i_lzb = 1 -> digits 5, 4 and 3 show 7'h7F; digit 2 shows 7'h0F; digit 1 shows 7'h01; digit 0 shows 7'h24. With i_digit = 0, only digit 0 shows 7'h01.
REQ-030 i_blink = 6'b000001 -> digit 0 shows its glyph for 2 frames, then 7'h7F for 2 frames, and repeats; other digits are steady.
REQ-031 i_digit changed while digit 3 is active -> no output change until the digit shown after the next o_frame pulse.
REQ-032 rst pulsed for 1 clk while digit 4 is active -> the next edge gives the reset values, then REQ-025 behaviour; the blink phase restarts at 0.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Six-digit multiplexed 7-segment scan controller. Inputs are frozen into a
// per-frame snapshot; leading-zero blanking and per-digit blink act on it.
module seg_scan_ctrl #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 83
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] i_digit,
  input  logic [5:0]  i_dp,
  input  logic        i_lzb,
  input  logic [5:0]  i_blink,
  output logic [5:0]  o_seg_enb,
  output logic [6:0]  o_seg,
  output logic        o_seg_dp,
  output logic        o_frame
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PRESC_PRE  = PW'(SCAN_DIV - 2);
  localparam logic [FW-1:0] FCNT_LAST  = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0] r_presc;
  logic [2:0]    r_idx;
  logic [FW-1:0] r_fcnt;
  logic          r_phase;
  logic [23:0]   r_snap_digit;
  logic [5:0]    r_snap_dp;
  logic          r_snap_lzb;
  logic [5:0]    r_snap_blink;
  logic          r_frame;
  logic [5:0]    r_seg_enb;
  logic [6:0]    r_seg;
  logic          r_seg_dp;

  logic          w_tick;
  logic          w_load;
  logic [5:0]    w_lz;
  logic [3:0]    w_nib;
  logic          w_dp_req;
  logic          w_blink_req;
  logic          w_lead;
  logic [6:0]    w_seg;
  logic          w_seg_dp;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h01;
      4'h1: s = 7'h4F;
      4'h2: s = 7'h12;
      4'h3: s = 7'h06;
      4'h4: s = 7'h4C;
      4'h5: s = 7'h24;
      4'h6: s = 7'h20;
      4'h7: s = 7'h0F;
      4'h8: s = 7'h00;
      4'h9: s = 7'h04;
      4'hA: s = 7'h08;
      4'hB: s = 7'h60;
      4'hC: s = 7'h31;
      4'hD: s = 7'h42;
      4'hE: s = 7'h30;
      default: s = 7'h38;
    endcase
    return s;
  endfunction

  assign w_tick = (r_presc == PRESC_LAST);
  assign w_load = w_tick && (r_idx == 3'd5);

  // w_lz[k]: snapshot digits 5..k are all zero
  for (genvar k = 0; k < 6; k++) begin : g_lz
    assign w_lz[k] = (r_snap_digit[23:4*k] == '0);
  end

  always_comb begin
    w_nib       = 4'h0;
    w_dp_req    = 1'b0;
    w_blink_req = 1'b0;
    w_lead      = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (r_idx == 3'(k)) begin
        w_nib       = r_snap_digit[4*k +: 4];
        w_dp_req    = r_snap_dp[k];
        w_blink_req = r_snap_blink[k];
        w_lead      = w_lz[k];
      end
    end
  end

  always_comb begin
    w_seg    = hex7(w_nib);
    w_seg_dp = ~w_dp_req;
    if (r_snap_lzb && (r_idx != 3'd0) && w_lead) begin
      w_seg = 7'h7F;
    end
    if (r_phase && w_blink_req) begin
      w_seg    = 7'h7F;
      w_seg_dp = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc      <= '0;
      r_idx        <= 3'd0;
      r_fcnt       <= '0;
      r_phase      <= 1'b0;
      r_snap_digit <= '0;
      r_snap_dp    <= '0;
      r_snap_lzb   <= 1'b0;
      r_snap_blink <= '0;
      r_frame      <= 1'b0;
      r_seg_enb    <= 6'h3F;
      r_seg        <= 7'h7F;
      r_seg_dp     <= 1'b1;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) begin
        r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
      end
      if (w_load) begin
        r_snap_digit <= i_digit;
        r_snap_dp    <= i_dp;
        r_snap_lzb   <= i_lzb;
        r_snap_blink <= i_blink;
        if (r_fcnt == FCNT_LAST) begin
          r_fcnt  <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_fcnt <= r_fcnt + FW'(1);
        end
      end
      // Registered one cycle early so the pulse lines up with the load tick
      r_frame   <= (r_presc == PRESC_PRE) && (r_idx == 3'd5);
      r_seg_enb <= ~(6'b000001 << r_idx);
      r_seg     <= w_seg;
      r_seg_dp  <= w_seg_dp;
    end
  end

  assign o_seg_enb = r_seg_enb;
  assign o_seg     = r_seg;
  assign o_seg_dp  = r_seg_dp;
  assign o_frame   = r_frame;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized scoreboard bench for seg_scan_ctrl: a cycle-count reference
// model queues expected outputs, a monitor compares them every cycle.
module tb_seg_scan_ctrl;
  localparam int D     = 4;
  localparam int BF    = 2;
  localparam int FRAME = 6 * D;
  localparam int NCYC  = 6000;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] i_digit;
  logic [5:0]  i_dp;
  logic        i_lzb;
  logic [5:0]  i_blink;
  logic [5:0]  o_seg_enb;
  logic [6:0]  o_seg;
  logic        o_seg_dp;
  logic        o_frame;

  typedef struct packed {
    logic [5:0] enb;
    logic [6:0] seg;
    logic       dp;
    logic       frame;
  } out_t;

  out_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  seg_scan_ctrl #(.SCAN_DIV(D), .BLINK_FRAMES(BF)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_digit   (i_digit),
    .i_dp      (i_dp),
    .i_lzb     (i_lzb),
    .i_blink   (i_blink),
    .o_seg_enb (o_seg_enb),
    .o_seg     (o_seg),
    .o_seg_dp  (o_seg_dp),
    .o_frame   (o_frame)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'h01;   1: return 7'h4F;   2: return 7'h12;   3: return 7'h06;
      4: return 7'h4C;   5: return 7'h24;   6: return 7'h20;   7: return 7'h0F;
      8: return 7'h00;   9: return 7'h04;  10: return 7'h08;  11: return 7'h60;
      12: return 7'h31; 13: return 7'h42;  14: return 7'h30;  default: return 7'h38;
    endcase
  endfunction

  function automatic out_t ref_disp(input int idx, input logic [23:0] dig,
                                    input logic [5:0] dp, input logic lzb,
                                    input logic [5:0] bl, input bit phase);
    out_t o;
    o.enb      = 6'h3F;
    o.enb[idx] = 1'b0;
    o.seg      = glyph(int'((dig >> (4 * idx)) & 24'hF));
    if (lzb && idx > 0 && ((dig >> (4 * idx)) == 24'h0)) o.seg = 7'h7F;
    o.dp = ~dp[idx];
    if (phase && bl[idx]) begin
      o.seg = 7'h7F;
      o.dp  = 1'b1;
    end
    o.frame = 1'b0;
    return o;
  endfunction

  // m = clock edges since the last reset edge; loads = snapshots taken
  initial begin : model
    int          m;
    int          loads;
    bit          active;
    logic [23:0] s_dig;
    logic [5:0]  s_dp;
    logic [5:0]  s_bl;
    logic        s_lzb;
    out_t        e;
    active = 0;
    m = 0;
    loads = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m = 0; loads = 0; active = 1;
        s_dig = '0; s_dp = '0; s_bl = '0; s_lzb = 1'b0;
        exp_q.push_back({6'h3F, 7'h7F, 1'b1, 1'b0});
      end else if (active) begin
        e = ref_disp((m / D) % 6, s_dig, s_dp, s_lzb, s_bl, ((loads / BF) % 2) == 1);
        if (m % FRAME == FRAME - 1) begin
          s_dig = i_digit; s_dp = i_dp; s_lzb = i_lzb; s_bl = i_blink;
          loads++;
        end
        m++;
        e.frame = (m % FRAME == FRAME - 1);
        exp_q.push_back(e);
      end
    end
  end

  initial begin : monitor
    out_t e;
    out_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {o_seg_enb, o_seg, o_seg_dp, o_frame};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs t=%0t got enb=%h seg=%h dp=%b frame=%b expected enb=%h seg=%h dp=%b frame=%b",
                   $time, a.enb, a.seg, a.dp, a.frame, e.enb, e.seg, e.dp, e.frame);
        end
      end
    end
  end

  function automatic logic [23:0] rand_digits();
    logic [23:0] d;
    int nz;
    d  = 24'($urandom);
    nz = $urandom_range(0, 6);
    for (int k = 6 - nz; k < 6; k++) d[4*k +: 4] = 4'h0;
    return d;
  endfunction

  initial begin : stim
    rst     = 1'b1;
    i_digit = 24'h123456;
    i_dp    = 6'b000100;
    i_lzb   = 1'b0;
    i_blink = 6'b000000;
    @(posedge clk);
    #2 rst = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #2;
      rst = ($urandom_range(0, 799) == 0) || (c == 3001);
      if ($urandom_range(0, 99) < 3) i_digit = rand_digits();
      if ($urandom_range(0, 99) < 2) i_dp = 6'($urandom);
      if ($urandom_range(0, 99) < 2) i_lzb = 1'($urandom);
      if ($urandom_range(0, 99) < 2) i_blink = ($urandom_range(0, 1) == 1) ? 6'($urandom) : 6'b000001;
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0 || n_tests < NCYC) begin
      n_fail++;
      $display("FAIL drain pending=%0d compared=%0d required pending=0 compared>=%0d",
               exp_q.size(), n_tests, NCYC);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
